wb_ctrl: RTL and testbench
==========================

WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, number of buffered long-latency results (power of two, 2..4).
REQ-002 Parameter STARVE_MAX, default 4, consecutive blocked drain cycles before a stall request.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rstn  in  1  reset; synchronous, active-high (asserted = 1'b1 = `RstEnable).
REQ-005 pipe_wen_i  in  1  in-order pipeline result valid this cycle (from mem/wb register).
REQ-006 pipe_waddr_i  in  5  pipeline destination register.
REQ-007 pipe_wdata_i  in  32  pipeline result data.
REQ-008 div_valid_i  in  1  long-latency (mul/div) result offered.
REQ-009 div_ready_o  out  1  result buffer can accept this cycle.
REQ-010 div_waddr_i  in  5  long-latency destination register.
REQ-011 div_wdata_i  in  32  long-latency result data.
REQ-012 wen_o  out  1  regfile write enable (`WriteEnable when 1).
REQ-013 wr_addr_o  out  5  regfile write address.
REQ-014 wr_data_o  out  32  regfile write data.
REQ-015 pend_mask_o  out  32  bit k set = a buffered write to register k is outstanding.
REQ-016 stall_req_o  out  1  request to ID to insert a pipeline bubble.

Function
REQ-017 wen_o/wr_addr_o/wr_data_o SHALL be registered; exactly one write per cycle maximum.
REQ-018 Pipeline source SHALL have absolute priority and is never back-pressured; pipe result issued at cycle N SHALL appear on wen_o at N+1.
REQ-019 Pipeline write with pipe_waddr_i==0 SHALL be dropped (wen_o=0) and SHALL count as a free port cycle.
REQ-020 Long-latency handshake: transfer occurs when div_valid_i && div_ready_o; div_ready_o = !full, from registered state only (no combinational path from inputs).
REQ-021 Accepted entries SHALL enter a FIFO_DEPTH-entry FIFO; entries with div_waddr_i==0 SHALL be accepted and discarded (not enqueued).
REQ-022 FIFO head SHALL drain to the write port in any cycle the port is free; enqueue-to-write earliest latency is 2 cycles (no bypass around the FIFO).
REQ-023 Simultaneous enqueue and dequeue SHALL be legal when not full; count unchanged, pointers wrap modulo FIFO_DEPTH.
REQ-024 pend_mask_o SHALL be the OR of one-hot decodes of all valid FIFO entries, registered-state based.
REQ-025 starve_cnt SHALL increment each cycle the FIFO is non-empty and the port is taken by the pipeline, clear on any drain or when empty, saturate at STARVE_MAX.
REQ-026 stall_req_o SHALL be 1 when starve_cnt==STARVE_MAX or FIFO full; ID then guarantees pipe_wen_i=0 next cycle.
REQ-027 Ordering: FIFO drains strictly in acceptance order; WAW against the pipeline is prevented upstream using pend_mask_o.

Reset
REQ-028 On rstn=1 at posedge: wen_o=0, wr_addr_o=0, wr_data_o=0, FIFO empty, pointers=0, starve_cnt=0, pend_mask_o=0, div_ready_o=1 next cycle, stall_req_o=0.
REQ-029 Reset mid-operation SHALL discard all buffered entries and any in-flight write; no write issues in the cycle after reset.

Structure
REQ-030 Register address width (5), data width (32), register count (32), WriteEnable/RstEnable values SHALL come from the shared defines file.
REQ-031 FIFO SHALL be a sub-module wb_fifo (parameterised depth/width, push/pop/full/empty/count), instantiated once.

Verification
REQ-032 Pipe write x5=0x1234_5678 at cycle 10 -> wen_o=1, wr_addr_o=5, wr_data_o=0x1234_5678 at cycle 11; x0 write -> wen_o=0.
REQ-033 div result x7=0xDEAD_BEEF accepted at cycle 20, pipe idle -> write x7 at cycle 22; pend_mask_o bit 7 set cycles 21-22, clear at 23.
REQ-034 Two div results back-to-back with pipe busy -> div_ready_o=0 after second, stall_req_o=1, third div_valid_i held until drain; writes in acceptance order.
REQ-035 FIFO 1 entry, pipe writes 4 consecutive cycles -> stall_req_o=1 in following cycle; bubble drains entry, starve_cnt=0.
REQ-036 FIFO full, rstn=1 for one cycle -> no further writes, pend_mask_o=0, div_ready_o=1 after reset.
REQ-037 div x0 accepted -> no write ever issued, pend_mask_o stays 0.

Source files
------------

// File: rtl/wb_ctrl_pkg.sv
// Shared register-file constants and the write-request record used by the writeback controller.
package wb_ctrl_pkg;

    localparam int   REG_AW       = 5;
    localparam int   REG_DW       = 32;
    localparam int   REG_NUM      = 32;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic RST_ENABLE   = 1'b1;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] reg_data_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wb_req_t;

    localparam int WB_REQ_W = $bits(wb_req_t);

    function automatic logic [REG_NUM-1:0] reg_onehot(input reg_addr_t a);
        logic [REG_NUM-1:0] m;
        m    = '0;
        m[a] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Generic circular FIFO exposing its storage and per-slot valid bits for occupancy decoding.
// Latency: push visible at head the cycle after the push edge; no bypass.
// Backpressure: push ignored when full, pop ignored when empty.
module wb_fifo
    import wb_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_dat,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [DEPTH-1:0][WIDTH-1:0]  mem_dat,
    output logic [DEPTH-1:0]             mem_vld
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [AW-1:0]               off;
    logic                        do_push;
    logic                        do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];
    assign mem_dat = mem;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rstn == RST_ENABLE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // A slot holds live data when its distance from the read pointer is below the count.
    always_comb begin
        mem_vld = '0;
        off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = AW'(i) - rd_ptr;
            mem_vld[i] = (CW'(off) < count);
        end
    end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback arbiter: in-order pipeline results win the regfile port, mul/div results queue behind them.
// Latency: pipeline 1 cycle; buffered results at least 2 cycles from acceptance.
// Backpressure: pipeline never stalled here; div side ready = !full, stall_req_o on full or starvation.
module wb_ctrl
    import wb_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               pipe_wen_i,
    input  logic [REG_AW-1:0]  pipe_waddr_i,
    input  logic [REG_DW-1:0]  pipe_wdata_i,
    input  logic               div_valid_i,
    output logic               div_ready_o,
    input  logic [REG_AW-1:0]  div_waddr_i,
    input  logic [REG_DW-1:0]  div_wdata_i,
    output logic               wen_o,
    output logic [REG_AW-1:0]  wr_addr_o,
    output logic [REG_DW-1:0]  wr_data_o,
    output logic [REG_NUM-1:0] pend_mask_o,
    output logic               stall_req_o
);

    localparam int SW = $clog2(STARVE_MAX+1);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic                                 pipe_take;
    logic                                 fifo_push;
    logic                                 fifo_pop;
    logic                                 fifo_full;
    logic                                 fifo_empty;
    logic [CW-1:0]                        fifo_count;
    logic [WB_REQ_W-1:0]                  fifo_head;
    logic [FIFO_DEPTH-1:0][WB_REQ_W-1:0]  fifo_mem;
    logic [FIFO_DEPTH-1:0]                fifo_vld;
    wb_req_t                              head;
    wb_req_t                              entry;
    logic                                 wr_from_fifo;
    logic [SW-1:0]                        starve_cnt;

    // Writes to x0 are architecturally dead, so they leave the port free for a drain.
    assign pipe_take   = pipe_wen_i && (pipe_waddr_i != '0);
    assign div_ready_o = !fifo_full;
    assign fifo_push   = div_valid_i && div_ready_o && (div_waddr_i != '0);
    assign fifo_pop    = !fifo_empty && !pipe_take;
    assign head        = fifo_head;
    assign stall_req_o = (starve_cnt == SW'(STARVE_MAX)) || (fifo_count == CW'(FIFO_DEPTH));

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WB_REQ_W)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (fifo_push),
        .push_dat (WB_REQ_W'({div_waddr_i, div_wdata_i})),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .mem_dat  (fifo_mem),
        .mem_vld  (fifo_vld)
    );

    always_ff @(posedge clk) begin
        if (rstn == RST_ENABLE) begin
            wen_o        <= ~WRITE_ENABLE;
            wr_addr_o    <= '0;
            wr_data_o    <= '0;
            wr_from_fifo <= 1'b0;
            starve_cnt   <= '0;
        end else begin
            if (pipe_take) begin
                wen_o        <= WRITE_ENABLE;
                wr_addr_o    <= pipe_waddr_i;
                wr_data_o    <= pipe_wdata_i;
                wr_from_fifo <= 1'b0;
            end else if (fifo_pop) begin
                wen_o        <= WRITE_ENABLE;
                wr_addr_o    <= head.addr;
                wr_data_o    <= head.data;
                wr_from_fifo <= 1'b1;
            end else begin
                wen_o        <= ~WRITE_ENABLE;
                wr_from_fifo <= 1'b0;
            end

            // Non-empty without a pop means the pipeline owned the port this cycle.
            if (fifo_empty || fifo_pop) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    // A drained entry stays pending until its write lands in the regfile at the end of the cycle.
    always_comb begin
        pend_mask_o = '0;
        entry       = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld[i]) begin
                entry       = fifo_mem[i];
                pend_mask_o = pend_mask_o | reg_onehot(entry.addr);
            end
        end
        if ((wen_o == WRITE_ENABLE) && wr_from_fifo) begin
            pend_mask_o = pend_mask_o | reg_onehot(wr_addr_o);
        end
    end

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed and randomized checks of wb_ctrl against a queue-based model of the writeback rules.
`timescale 1ns/1ps
module tb_wb_ctrl;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        pipe_wen_i;
    logic [4:0]  pipe_waddr_i;
    logic [31:0] pipe_wdata_i;
    logic        div_valid_i;
    logic        div_ready_o;
    logic [4:0]  div_waddr_i;
    logic [31:0] div_wdata_i;
    logic        wen_o;
    logic [4:0]  wr_addr_o;
    logic [31:0] wr_data_o;
    logic [31:0] pend_mask_o;
    logic        stall_req_o;

    wb_ctrl #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .pipe_wen_i   (pipe_wen_i),
        .pipe_waddr_i (pipe_waddr_i),
        .pipe_wdata_i (pipe_wdata_i),
        .div_valid_i  (div_valid_i),
        .div_ready_o  (div_ready_o),
        .div_waddr_i  (div_waddr_i),
        .div_wdata_i  (div_wdata_i),
        .wen_o        (wen_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .pend_mask_o  (pend_mask_o),
        .stall_req_o  (stall_req_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    // Reference model: what the regfile port should show after each edge.
    ent_t        m_q[$];
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_from_q;
    int          m_starve;

    int tests_run    = 0;
    int tests_failed = 0;

    function automatic logic [31:0] exp_pend();
        logic [31:0] m;
        m = '0;
        foreach (m_q[i]) m[m_q[i].addr] = 1'b1;
        if (m_wen && m_from_q) m[m_addr] = 1'b1;
        return m;
    endfunction

    function automatic logic exp_ready();
        return m_q.size() < DEPTH;
    endfunction

    function automatic logic exp_stall();
        return (m_starve == SMAX) || (m_q.size() == DEPTH);
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_wen    = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        m_from_q = 1'b0;
        m_starve = 0;
    endtask

    task automatic do_reset();
        rstn         = 1'b1;
        pipe_wen_i   = 1'b0;
        pipe_waddr_i = '0;
        pipe_wdata_i = '0;
        div_valid_i  = 1'b0;
        div_waddr_i  = '0;
        div_wdata_i  = '0;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        rstn = 1'b0;
    endtask

    // Presents one cycle of inputs, advances the model, returns after the edge with outputs settled.
    task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic dv, input logic [4:0] da, input logic [31:0] dd);
        bit   busy, rdy, was_empty, drained;
        ent_t e;
        pipe_wen_i   = pw;
        pipe_waddr_i = pa;
        pipe_wdata_i = pd;
        div_valid_i  = dv;
        div_waddr_i  = da;
        div_wdata_i  = dd;
        busy      = pw && (pa != 0);
        rdy       = exp_ready();
        was_empty = (m_q.size() == 0);
        drained   = 1'b0;
        if (busy) begin
            m_wen = 1'b1; m_addr = pa; m_data = pd; m_from_q = 1'b0;
        end else if (!was_empty) begin
            e = m_q.pop_front();
            m_wen = 1'b1; m_addr = e.addr; m_data = e.data; m_from_q = 1'b1;
            drained = 1'b1;
        end else begin
            m_wen = 1'b0; m_from_q = 1'b0;
        end
        if (was_empty || drained) m_starve = 0;
        else if (m_starve < SMAX) m_starve++;
        if (dv && rdy && (da != 0)) m_q.push_back('{addr: da, data: dd});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (wen_o !== 1'b0) begin tests_failed++; $display("FAIL reset_wen: got %b want 0", wen_o); end
        tests_run++; if (wr_addr_o !== 5'd0) begin tests_failed++; $display("FAIL reset_addr: got %0d want 0", wr_addr_o); end
        tests_run++; if (wr_data_o !== 32'd0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", wr_data_o); end
        tests_run++; if (pend_mask_o !== 32'd0) begin tests_failed++; $display("FAIL reset_pend: got %h want 0", pend_mask_o); end
        tests_run++; if (div_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", div_ready_o); end
        tests_run++; if (stall_req_o !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", stall_req_o); end
    endtask

    task automatic test_pipe_write();
        drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
        tests_run++; if (wen_o !== 1'b1) begin tests_failed++; $display("FAIL pipe_wen: got %b want 1", wen_o); end
        tests_run++; if (wr_addr_o !== 5'd5) begin tests_failed++; $display("FAIL pipe_addr: got %0d want 5", wr_addr_o); end
        tests_run++; if (wr_data_o !== 32'h1234_5678) begin tests_failed++; $display("FAIL pipe_data: got %h want 12345678", wr_data_o); end
        drive(1'b1, 5'd0, 32'h0000_CAFE, 1'b0, 5'd0, 32'd0);
        tests_run++; if (wen_o !== 1'b0) begin tests_failed++; $display("FAIL pipe_x0_wen: got %b want 0", wen_o); end
        idle();
    endtask

    task automatic test_div_latency();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD_BEEF);
        tests_run++; if (wen_o !== 1'b0) begin tests_failed++; $display("FAIL div_lat_early: got wen %b want 0", wen_o); end
        tests_run++; if (pend_mask_o !== 32'h0000_0080) begin tests_failed++; $display("FAIL div_pend_c21: got %h want 00000080", pend_mask_o); end
        idle();
        tests_run++; if ({wen_o, wr_addr_o, wr_data_o} !== {1'b1, 5'd7, 32'hDEAD_BEEF}) begin tests_failed++; $display("FAIL div_write: got wen %b addr %0d data %h want 1 7 deadbeef", wen_o, wr_addr_o, wr_data_o); end
        tests_run++; if (pend_mask_o !== 32'h0000_0080) begin tests_failed++; $display("FAIL div_pend_c22: got %h want 00000080", pend_mask_o); end
        idle();
        tests_run++; if (pend_mask_o !== 32'd0) begin tests_failed++; $display("FAIL div_pend_c23: got %h want 0", pend_mask_o); end
        tests_run++; if (wen_o !== 1'b0) begin tests_failed++; $display("FAIL div_single_write: got wen %b want 0", wen_o); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'hA3);
        tests_run++; if (wr_addr_o !== 5'd1) begin tests_failed++; $display("FAIL b2b_pipe1: got addr %0d want 1", wr_addr_o); end
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'hB4);
        tests_run++; if (div_ready_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_full: got %b want 0", div_ready_o); end
        tests_run++; if (stall_req_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_stall_full: got %b want 1", stall_req_o); end
        tests_run++; if (pend_mask_o !== 32'h0000_0018) begin tests_failed++; $display("FAIL b2b_pend_full: got %h want 00000018", pend_mask_o); end
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hC6);
        tests_run++; if ({wen_o, wr_addr_o, wr_data_o} !== {1'b1, 5'd3, 32'hA3}) begin tests_failed++; $display("FAIL b2b_first: got %b %0d %h want 1 3 a3", wen_o, wr_addr_o, wr_data_o); end
        tests_run++; if (div_ready_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_again: got %b want 1", div_ready_o); end
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hC6);
        tests_run++; if ({wen_o, wr_addr_o, wr_data_o} !== {1'b1, 5'd4, 32'hB4}) begin tests_failed++; $display("FAIL b2b_second: got %b %0d %h want 1 4 b4", wen_o, wr_addr_o, wr_data_o); end
        tests_run++; if (pend_mask_o !== 32'h0000_0050) begin tests_failed++; $display("FAIL b2b_pend_mid: got %h want 00000050", pend_mask_o); end
        idle();
        tests_run++; if ({wen_o, wr_addr_o, wr_data_o} !== {1'b1, 5'd6, 32'hC6}) begin tests_failed++; $display("FAIL b2b_third: got %b %0d %h want 1 6 c6", wen_o, wr_addr_o, wr_data_o); end
        idle();
        tests_run++; if (pend_mask_o !== 32'd0) begin tests_failed++; $display("FAIL b2b_pend_end: got %h want 0", pend_mask_o); end
    endtask

    task automatic test_starve();
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h99);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'(10 + k), 32'(k), 1'b0, 5'd0, 32'd0);
            tests_run++; if (stall_req_o !== (k == 3)) begin tests_failed++; $display("FAIL starve_stall_%0d: got %b want %b", k, stall_req_o, (k == 3)); end
            tests_run++; if (wr_addr_o !== 5'(10 + k)) begin tests_failed++; $display("FAIL starve_pipe_%0d: got addr %0d want %0d", k, wr_addr_o, 10 + k); end
        end
        idle();
        tests_run++; if ({wen_o, wr_addr_o, wr_data_o} !== {1'b1, 5'd9, 32'h99}) begin tests_failed++; $display("FAIL starve_drain: got %b %0d %h want 1 9 99", wen_o, wr_addr_o, wr_data_o); end
        tests_run++; if (stall_req_o !== 1'b0) begin tests_failed++; $display("FAIL starve_clear: got %b want 0", stall_req_o); end
        idle();
    endtask

    task automatic test_reset_full();
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd3, 32'h3);
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd4, 32'h4);
        tests_run++; if (stall_req_o !== 1'b1) begin tests_failed++; $display("FAIL rstfull_pre: got stall %b want 1", stall_req_o); end
        do_reset();
        tests_run++; if (wen_o !== 1'b0) begin tests_failed++; $display("FAIL rstfull_wen: got %b want 0", wen_o); end
        tests_run++; if (pend_mask_o !== 32'd0) begin tests_failed++; $display("FAIL rstfull_pend: got %h want 0", pend_mask_o); end
        tests_run++; if (div_ready_o !== 1'b1) begin tests_failed++; $display("FAIL rstfull_ready: got %b want 1", div_ready_o); end
        tests_run++; if (stall_req_o !== 1'b0) begin tests_failed++; $display("FAIL rstfull_stall: got %b want 0", stall_req_o); end
        for (int k = 0; k < 3; k++) begin
            idle();
            tests_run++; if (wen_o !== 1'b0) begin tests_failed++; $display("FAIL rstfull_nowrite_%0d: got wen %b want 0", k, wen_o); end
        end
    endtask

    task automatic test_div_x0();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5555_5555);
        tests_run++; if (div_ready_o !== 1'b1) begin tests_failed++; $display("FAIL x0_ready: got %b want 1", div_ready_o); end
        for (int k = 0; k < 3; k++) begin
            tests_run++; if (pend_mask_o !== 32'd0) begin tests_failed++; $display("FAIL x0_pend_%0d: got %h want 0", k, pend_mask_o); end
            idle();
            tests_run++; if (wen_o !== 1'b0) begin tests_failed++; $display("FAIL x0_wen_%0d: got %b want 0", k, wen_o); end
        end
    endtask

    task automatic test_random();
        logic        pw, dv, prev_stall;
        logic [4:0]  pa, da;
        do_reset();
        prev_stall = 1'b0;
        for (int c = 0; c < 500; c++) begin
            pw = prev_stall ? 1'b0 : ($urandom_range(0, 9) < 6);
            pa = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            dv = 1'($urandom_range(0, 1));
            da = 5'($urandom_range(0, 7));
            prev_stall = exp_stall();
            drive(pw, pa, $urandom, dv, da, $urandom);
            tests_run++; if (wen_o !== m_wen) begin tests_failed++; $display("FAIL rnd_wen c%0d: got %b want %b", c, wen_o, m_wen); end
            if (m_wen) begin
                tests_run++; if ({wr_addr_o, wr_data_o} !== {m_addr, m_data}) begin tests_failed++; $display("FAIL rnd_wr c%0d: got %0d %h want %0d %h", c, wr_addr_o, wr_data_o, m_addr, m_data); end
            end
            tests_run++; if (pend_mask_o !== exp_pend()) begin tests_failed++; $display("FAIL rnd_pend c%0d: got %h want %h", c, pend_mask_o, exp_pend()); end
            tests_run++; if (div_ready_o !== exp_ready()) begin tests_failed++; $display("FAIL rnd_ready c%0d: got %b want %b", c, div_ready_o, exp_ready()); end
            tests_run++; if (stall_req_o !== exp_stall()) begin tests_failed++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall_req_o, exp_stall()); end
        end
    endtask

    initial begin
        rstn         = 1'b1;
        pipe_wen_i   = 1'b0;
        pipe_waddr_i = '0;
        pipe_wdata_i = '0;
        div_valid_i  = 1'b0;
        div_waddr_i  = '0;
        div_wdata_i  = '0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_pipe_write();
        test_div_latency();
        test_back_to_back();
        test_starve();
        test_reset_full();
        test_div_x0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
